// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op codes, FSM encoding, default width.
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_NOT = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Valid/ready front/back end around an external combinational ALU: issue, settle, capture, hand off.
// Optional ALU_DIVZ_GUARD_EN replaces a divide-by-zero result with all-ones and raises out_divz.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH  = ALU_WIDTH,
   parameter int SETTLE = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic             out_divz,
   output logic             busy
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   generate
      if (SETTLE < 1) begin : g_bad_settle
         $error("alu_issue_ctrl: SETTLE must be >= 1");
      end
   endgenerate

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a, r_b, r_y;
   logic [2:0]       r_op;
   logic             r_valid, r_zero;
   logic [WIDTH-1:0] w_cap_y;
   logic             w_cap_zero;

`ifdef ALU_DIVZ_GUARD_EN
   logic w_divz;
   logic r_divz;
   assign w_divz     = (r_op == OP_DIV) && (r_b == '0);
   assign w_cap_y    = w_divz ? '1 : alu_y;
   assign w_cap_zero = w_divz ? 1'b0 : (alu_y == '0);
   assign out_divz   = r_divz;
`else
   assign w_cap_y    = alu_y;
   assign w_cap_zero = (alu_y == '0);
   assign out_divz   = 1'b0;
`endif

   // Held low during reset so nothing can be accepted until release.
   assign in_ready  = (r_state == IDLE) && !reset;
   assign busy      = (r_state != IDLE);
   assign alu_a     = r_a;
   assign alu_b     = r_b;
   assign alu_op    = r_op;
   assign out_valid = r_valid;
   assign out_y     = r_y;
   assign out_zero  = r_zero;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_y     <= '0;
         r_zero  <= 1'b0;
         r_valid <= 1'b0;
`ifdef ALU_DIVZ_GUARD_EN
         r_divz  <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_op    <= in_op;
                  r_cnt   <= CW'(SETTLE - 1);
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               if (r_cnt == '0) begin
                  r_y     <= w_cap_y;
                  r_zero  <= w_cap_zero;
`ifdef ALU_DIVZ_GUARD_EN
                  r_divz  <= w_divz;
`endif
                  r_valid <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DONE: begin
               // Result and flags stay put after the handshake; only valid drops.
               if (out_ready) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a SETTLE=1 and a SETTLE=4 instance, each driven by a behavioural ALU.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   localparam int W = 8;
`ifdef ALU_DIVZ_GUARD_EN
   localparam logic [W-1:0] DZ_Y = 8'hFF;
   localparam logic         DZ_F = 1'b1;
`else
   localparam logic [W-1:0] DZ_Y = 8'hEE;
   localparam logic         DZ_F = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic v1, v4, out_ready;
   logic [W-1:0] in_a, in_b;
   logic [2:0] in_op;
   logic rdy1, ov1, z1, dz1, busy1, rdy4, ov4, z4, dz4, busy4;
   logic [W-1:0] a1, b1, y1, ay1, a4, b4, y4, ay4;
   logic [2:0] op1, op4;
   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   // Reference ALU; divide by zero yields a recognisable marker value.
   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
      case (op)
         OP_ADD: return a + b;
         OP_SUB: return a - b;
         OP_MUL: return a * b;
         OP_DIV: return (b == '0) ? 8'hEE : a / b;
         OP_AND: return a & b;
         OP_OR:  return a | b;
         OP_NOT: return ~a;
         default: return a ^ b;
      endcase
   endfunction

   assign ay1 = alu_f(a1, b1, op1);
   assign ay4 = alu_f(a4, b4, op4);

   alu_issue_ctrl #(.WIDTH(W), .SETTLE(1)) u_dut1 (
      .clock(clock), .reset(reset), .in_valid(v1), .in_ready(rdy1),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_y(ay1),
      .out_valid(ov1), .out_ready(out_ready), .out_y(y1),
      .out_zero(z1), .out_divz(dz1), .busy(busy1));

   alu_issue_ctrl #(.WIDTH(W), .SETTLE(4)) u_dut4 (
      .clock(clock), .reset(reset), .in_valid(v4), .in_ready(rdy4),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .alu_a(a4), .alu_b(b4), .alu_op(op4), .alu_y(ay4),
      .out_valid(ov4), .out_ready(out_ready), .out_y(y4),
      .out_zero(z4), .out_divz(dz4), .busy(busy4));

   // Issues one request on the SETTLE=1 instance with out_ready high; lat=-1 on timeout.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        output logic [W-1:0] y, output logic z, output logic dz, output int lat);
      in_a = a; in_b = b; in_op = op; v1 = 1'b1; out_ready = 1'b1;
      y = 'x; z = 1'bx; dz = 1'bx; lat = -1;
      @(posedge clock); #1 v1 = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clock); #1;
         if (ov1) begin lat = i; y = y1; z = z1; dz = dz1; break; end
      end
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if ({ov1, y1, z1, dz1, a1, b1, op1, busy1} !== '0) begin n_err++; $display("FAIL reset_outs1: got %h want 0", {ov1, y1, z1, dz1, a1, b1, op1, busy1}); end
      n_cmp++; if ({ov4, y4, z4, dz4, a4, b4, op4, busy4} !== '0) begin n_err++; $display("FAIL reset_outs4: got %h want 0", {ov4, y4, z4, dz4, a4, b4, op4, busy4}); end
      n_cmp++; if (rdy1 !== 1'b0) begin n_err++; $display("FAIL reset_rdy_held: got %b want 0", rdy1); end
      @(posedge clock); #1 reset = 1'b0; #1;
      n_cmp++; if ({rdy1, rdy4} !== 2'b11) begin n_err++; $display("FAIL reset_rdy_rel: got %b want 11", {rdy1, rdy4}); end
   endtask

   task automatic test_add_timing();
      in_a = 8'd7; in_b = 8'd3; in_op = OP_ADD; v1 = 1'b1; out_ready = 1'b1;
      @(posedge clock); #1 v1 = 1'b0;
      n_cmp++; if ({ov1, rdy1, busy1} !== 3'b001) begin n_err++; $display("FAIL add_c0 v/r/b: got %b want 001", {ov1, rdy1, busy1}); end
      n_cmp++; if ({a1, b1, op1} !== {8'd7, 8'd3, OP_ADD}) begin n_err++; $display("FAIL add_c0 alu_in: got %h want %h", {a1, b1, op1}, {8'd7, 8'd3, OP_ADD}); end
      @(posedge clock); #1;
      n_cmp++; if ({ov1, rdy1} !== 2'b10) begin n_err++; $display("FAIL add_c1 v/r: got %b want 10", {ov1, rdy1}); end
      n_cmp++; if ({y1, z1, dz1} !== {8'd10, 1'b0, 1'b0}) begin n_err++; $display("FAIL add_c1 y/z/dz: got %h want %h", {y1, z1, dz1}, {8'd10, 2'b00}); end
      @(posedge clock); #1;
      n_cmp++; if ({ov1, rdy1, busy1} !== 3'b010) begin n_err++; $display("FAIL add_c2 v/r/b: got %b want 010", {ov1, rdy1, busy1}); end
      n_cmp++; if (y1 !== 8'd10) begin n_err++; $display("FAIL add_c2 y_hold: got %0d want 10", y1); end
   endtask

   task automatic test_ops();
      logic [W-1:0] y; logic z, dz; int lat;
      do_op(8'd3, 8'd3, OP_SUB, y, z, dz, lat);
      n_cmp++; if ({lat == 1, y, z, dz} !== {1'b1, 8'd0, 1'b1, 1'b0}) begin n_err++; $display("FAIL sub_zero: got lat=%0d y=%0d z=%b dz=%b want lat=1 y=0 z=1 dz=0", lat, y, z, dz); end
      do_op(8'd20, 8'd13, OP_MUL, y, z, dz, lat);
      n_cmp++; if ({lat == 1, y, z} !== {1'b1, 8'd4, 1'b0}) begin n_err++; $display("FAIL mul_trunc: got lat=%0d y=%0d z=%b want lat=1 y=4 z=0", lat, y, z); end
      do_op(8'd20, 8'd3, OP_DIV, y, z, dz, lat);
      n_cmp++; if ({lat == 1, y, z, dz} !== {1'b1, 8'd6, 1'b0, 1'b0}) begin n_err++; $display("FAIL div_norm: got lat=%0d y=%0d z=%b dz=%b want y=6 z=0 dz=0", lat, y, z, dz); end
      do_op(8'd7, 8'd0, OP_DIV, y, z, dz, lat);
      n_cmp++; if ({lat == 1, y, z, dz} !== {1'b1, DZ_Y, 1'b0, DZ_F}) begin n_err++; $display("FAIL div_zero: got lat=%0d y=%h z=%b dz=%b want y=%h z=0 dz=%b", lat, y, z, dz, DZ_Y, DZ_F); end
      do_op(8'hF0, 8'h3C, OP_AND, y, z, dz, lat);
      n_cmp++; if ({lat == 1, y, dz} !== {1'b1, 8'h30, 1'b0}) begin n_err++; $display("FAIL and: got lat=%0d y=%h dz=%b want y=30 dz=0", lat, y, dz); end
      do_op(8'hFF, 8'h00, OP_NOT, y, z, dz, lat);
      n_cmp++; if ({lat == 1, y, z} !== {1'b1, 8'h00, 1'b1}) begin n_err++; $display("FAIL not_zero: got lat=%0d y=%h z=%b want y=00 z=1", lat, y, z); end
      do_op(8'hFF, 8'h01, OP_ADD, y, z, dz, lat);
      n_cmp++; if ({lat == 1, y, z} !== {1'b1, 8'h00, 1'b1}) begin n_err++; $display("FAIL add_wrap: got lat=%0d y=%h z=%b want y=00 z=1", lat, y, z); end
   endtask

   task automatic test_backpressure();
      in_a = 8'd7; in_b = 8'd3; in_op = OP_XOR; v1 = 1'b1; out_ready = 1'b0;
      @(posedge clock); #1 v1 = 1'b0;
      @(posedge clock); #1;
      n_cmp++; if ({ov1, y1} !== {1'b1, 8'd4}) begin n_err++; $display("FAIL bp_first: got v=%b y=%0d want v=1 y=4", ov1, y1); end
      in_a = 8'd9; in_b = 8'd5; in_op = OP_ADD; v1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         n_cmp++; if ({ov1, y1, rdy1, a1, b1} !== {1'b1, 8'd4, 1'b0, 8'd7, 8'd3}) begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b y=%0d rdy=%b a=%0d b=%0d want 1 4 0 7 3", i, ov1, y1, rdy1, a1, b1); end
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      n_cmp++; if ({ov1, rdy1, a1, y1} !== {1'b0, 1'b1, 8'd7, 8'd4}) begin n_err++; $display("FAIL bp_hs: got v=%b rdy=%b a=%0d y=%0d want 0 1 7 4", ov1, rdy1, a1, y1); end
      @(posedge clock); #1 v1 = 1'b0;
      n_cmp++; if ({a1, b1, op1, rdy1} !== {8'd9, 8'd5, OP_ADD, 1'b0}) begin n_err++; $display("FAIL bp_accept2: got a=%0d b=%0d op=%0d rdy=%b want 9 5 0 0", a1, b1, op1, rdy1); end
      @(posedge clock); #1;
      n_cmp++; if ({ov1, y1} !== {1'b1, 8'd14}) begin n_err++; $display("FAIL bp_second: got v=%b y=%0d want v=1 y=14", ov1, y1); end
      @(posedge clock); #1;
   endtask

   task automatic test_settle4();
      in_a = 8'd5; in_b = 8'd6; in_op = OP_ADD; v4 = 1'b1; out_ready = 1'b1;
      @(posedge clock); #1 v4 = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clock); #1;
         n_cmp++; if ({ov4, busy4} !== 2'b01) begin n_err++; $display("FAIL s4_early[%0d]: got v/busy=%b want 01", i, {ov4, busy4}); end
      end
      @(posedge clock); #1;
      n_cmp++; if ({ov4, y4} !== {1'b1, 8'd11}) begin n_err++; $display("FAIL s4_cap: got v=%b y=%0d want v=1 y=11", ov4, y4); end
      @(posedge clock); #1;
      n_cmp++; if ({ov4, rdy4} !== 2'b01) begin n_err++; $display("FAIL s4_idle: got v/rdy=%b want 01", {ov4, rdy4}); end
   endtask

   task automatic test_reset_mid();
      int pulses;
      pulses = 0;
      in_a = 8'd9; in_b = 8'd9; in_op = OP_ADD; v4 = 1'b1; out_ready = 1'b1;
      @(posedge clock); #1 v4 = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1 reset = 1'b1; #1;
      n_cmp++; if ({ov4, y4, z4, dz4, a4, b4, op4, busy4, rdy4} !== '0) begin n_err++; $display("FAIL rmid_outs: got %h want 0", {ov4, y4, z4, dz4, a4, b4, op4, busy4, rdy4}); end
      @(posedge clock); #1 reset = 1'b0; #1;
      n_cmp++; if ({rdy4, busy4} !== 2'b10) begin n_err++; $display("FAIL rmid_rel: got rdy/busy=%b want 10", {rdy4, busy4}); end
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         if (ov4) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rmid_nopulse: got %0d valid cycles want 0", pulses); end
   endtask

   initial begin
      v1 = 1'b0; v4 = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_op = '0;
      test_reset();
      test_add_timing();
      test_ops();
      test_backpressure();
      test_settle4();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
